// File: rtl/crp_mem_responder_if.sv
// crp_mem_responder_if: CRP CPU memory request/response bus between the CPU (master) and a memory responder (slave)
interface crp_mem_responder_if;
   logic [14:0] mem_req_bus;
   logic        mem_write_req;
   logic [7:0]  mem_read_bus;
   modport master (output mem_req_bus, output mem_write_req, input mem_read_bus);
   modport slave (input mem_req_bus, input mem_write_req, output mem_read_bus);
endinterface

// File: rtl/crp_mem_responder.sv
// crp_mem_responder: flop-based byte RAM target for the CRP memory bus; optional memory-mapped I/O under MEM_RESP_IO_EN
module crp_mem_responder #(
   parameter int         DEPTH = 32,
   parameter int         AW    = 5,
   parameter logic [7:0] FILL  = 8'h00
) (
   input  logic                 clk,
   input  logic                 rst_n,
   crp_mem_responder_if.slave   bus,
   input  logic [7:0]           io_in,
   output logic [7:0]           io_out
);
   typedef enum logic {ST_ADDR, ST_WDATA} state_t;
   state_t      r_state;
   state_t      w_next;
   logic [14:0] r_wr_addr;
   logic [7:0]  r_rd_data;
   logic [7:0]  w_rd_data;
   logic        w_rd_en;
   logic        w_wr_ram;
   logic [7:0]  r_mem [DEPTH];
`ifdef MEM_RESP_IO_EN
   logic [7:0]  r_io_out;
   logic [7:0]  r_sync [2];
   logic        w_wr_io;
`else
   logic        w_unused_io;
`endif

   assign bus.mem_read_bus = r_rd_data;

   // State register: ADDR accepts a request, WDATA consumes the write data beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_ADDR;
      else        r_state <= w_next;
   end

   // Next state and request decode; WDATA always returns to ADDR and ignores mem_write_req
   always_comb begin
      w_next   = (r_state == ST_ADDR) ? (bus.mem_write_req ? ST_WDATA : ST_ADDR) : ST_ADDR;
      w_rd_en  = (r_state == ST_ADDR) && !bus.mem_write_req;
      w_wr_ram = (r_state == ST_WDATA) && (r_wr_addr < 15'(DEPTH));
   end

   // Read mux: full 15-bit compare so upper address bits never alias into the RAM
   always_comb begin
      w_rd_data = (bus.mem_req_bus < 15'(DEPTH)) ? r_mem[bus.mem_req_bus[AW-1:0]] : FILL;
`ifdef MEM_RESP_IO_EN
      w_rd_data = (bus.mem_req_bus == 15'h7FFF) ? r_io_out :
                  (bus.mem_req_bus == 15'h7FFE) ? r_sync[1] : w_rd_data;
`endif
   end

   // Address latch for writes and registered read data (holds except on a read request)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_addr <= 15'h0000;
         r_rd_data <= 8'h00;
      end else begin
         if (r_state == ST_ADDR && bus.mem_write_req) r_wr_addr <= bus.mem_req_bus;
         if (w_rd_en) r_rd_data <= w_rd_data;
      end
   end

   // Backing RAM; async reset clears every byte, which also aborts a write caught mid-data-phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
      else if (w_wr_ram) r_mem[r_wr_addr[AW-1:0]] <= bus.mem_req_bus[7:0];
   end

`ifdef MEM_RESP_IO_EN
   assign w_wr_io = (r_state == ST_WDATA) && (r_wr_addr == 15'h7FFF);
   assign io_out  = r_io_out;

   // I/O output register written by the data phase of a write to 0x7FFF
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_io_out <= 8'h00;
      else if (w_wr_io) r_io_out <= bus.mem_req_bus[7:0];
   end

   // Two-flop synchroniser for the asynchronous io_in pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync[0] <= 8'h00;
         r_sync[1] <= 8'h00;
      end else begin
         r_sync[0] <= io_in;
         r_sync[1] <= r_sync[0];
      end
   end
`else
   assign io_out      = 8'h00;
   assign w_unused_io = ^io_in;
`endif
endmodule

// File: tb/tb_crp_mem_responder.sv
// tb_crp_mem_responder: randomized self-checking bench for crp_mem_responder against a byte-array reference model
module tb_crp_mem_responder;
   localparam int DEPTH = 32;
   localparam logic [7:0] FILL = 8'h00;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] io_in = 8'h00;
   logic [7:0] io_out;
   crp_mem_responder_if bus ();

   crp_mem_responder #(.DEPTH(DEPTH), .AW(5), .FILL(FILL)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .io_in(io_in), .io_out(io_out)
   );

   always #5 clk = ~clk;

   int         n_pass = 0;
   int         n_total = 0;
   logic [7:0] m_mem [DEPTH];
   logic [7:0] m_io_out = 8'h00;
   logic [7:0] m_io_in = 8'h00;
   logic [7:0] m_last = 8'h00;

   function automatic logic [7:0] model_rd(input logic [14:0] a);
      if (int'(a) < DEPTH) return m_mem[int'(a)];
`ifdef MEM_RESP_IO_EN
      if (a == 15'h7FFF) return m_io_out;
      if (a == 15'h7FFE) return m_io_in;
`endif
      return FILL;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      m_io_out = 8'h00;
      m_last = 8'h00;
   endtask

   task automatic do_write(input logic [14:0] a, input logic [7:0] d);
      bus.mem_req_bus = a;
      bus.mem_write_req = 1'b1;
      @(posedge clk); #1;
      bus.mem_req_bus = {7'($urandom), d};
      bus.mem_write_req = 1'($urandom);
      @(posedge clk); #1;
      if (int'(a) < DEPTH) m_mem[int'(a)] = d;
`ifdef MEM_RESP_IO_EN
      else if (a == 15'h7FFF) m_io_out = d;
`endif
      n_total++;
      if (bus.mem_read_bus !== m_last)
         $display("FAIL wr_hold addr=%h: mem_read_bus=%h expected=%h", a, bus.mem_read_bus, m_last);
      else n_pass++;
      n_total++;
      if (io_out !== m_io_out)
         $display("FAIL io_out after write addr=%h: got=%h expected=%h", a, io_out, m_io_out);
      else n_pass++;
   endtask

   task automatic do_read(input logic [14:0] a, input string nm);
      bus.mem_req_bus = a;
      bus.mem_write_req = 1'b0;
      @(posedge clk); #1;
      m_last = model_rd(a);
      n_total++;
      if (bus.mem_read_bus !== m_last)
         $display("FAIL %s addr=%h: mem_read_bus=%h expected=%h", nm, a, bus.mem_read_bus, m_last);
      else n_pass++;
   endtask

   task automatic test_reset();
      bus.mem_req_bus = 15'h0003;
      bus.mem_write_req = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if (bus.mem_read_bus !== 8'h00) $display("FAIL reset rd: got=%h expected=00", bus.mem_read_bus);
      else n_pass++;
      n_total++;
      if (io_out !== 8'h00) $display("FAIL reset io_out: got=%h expected=00", io_out);
      else n_pass++;
      rst_n = 1'b1;
      do_read(15'h0003, "reset_read3");
   endtask

   task automatic test_write_read();
      do_write(15'h0005, 8'hA5);
      do_read(15'h0005, "wr_rd5");
      do_write(15'h0020, 8'h77);
      do_read(15'h0020, "oob_0x20");
      do_read(15'h0000, "no_alias0");
      do_write(15'h4003, 8'h99);
      do_read(15'h0003, "no_alias_hi");
      do_read(15'h4003, "oob_hi");
   endtask

   task automatic test_back_to_back();
      do_write(15'h001F, 8'h11);
      do_write(15'h0000, 8'h22);
      do_write(15'h0010, 8'h33);
      do_read(15'h001F, "b2b_1f");
      do_read(15'h0000, "b2b_00");
      do_read(15'h0010, "b2b_10");
   endtask

   task automatic test_reset_mid_write();
      do_write(15'h0002, 8'h6C);
      do_read(15'h0002, "pre_abort");
      bus.mem_req_bus = 15'h0002;
      bus.mem_write_req = 1'b1;
      @(posedge clk); #1;
      bus.mem_req_bus = 15'h00FF;
      bus.mem_write_req = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_total++;
      if (bus.mem_read_bus !== 8'h00) $display("FAIL async_reset rd: got=%h expected=00", bus.mem_read_bus);
      else n_pass++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_read(15'h0002, "abort_wr2");
   endtask

   task automatic test_io();
      do_write(15'h7FFF, 8'h5A);
      do_read(15'h7FFF, "io_out_rd");
      io_in = 8'hC3;
      repeat (3) @(posedge clk);
      #1;
      m_io_in = 8'hC3;
      do_read(15'h7FFE, "io_in_rd");
      do_write(15'h7FFE, 8'h12);
      do_read(15'h7FFE, "io_in_wr_drop");
   endtask

   task automatic test_random();
      logic [14:0] a;
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 9))
            0:       a = 15'($urandom_range(32, 63));
            1:       a = 15'($urandom);
            2:       a = 15'h7FFE + 15'($urandom_range(0, 1));
            default: a = 15'($urandom_range(0, DEPTH - 1));
         endcase
         if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom));
         else do_read(a, "rand_rd");
      end
   endtask

   initial begin
      bus.mem_req_bus = 15'h0000;
      bus.mem_write_req = 1'b0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_reset_mid_write();
      test_io();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
